signed_divider_seq: RTL and testbench

- Sequential signed integer divider; the inverse operation of the FIR datapath's signed combinational multiplier.
- Takes an N-bit signed dividend and an m-bit signed divisor and produces an N-bit quotient and an m-bit remainder.
- Restoring algorithm, one quotient bit per clock.
- Used after accumulation for tap-gain normalisation and output scaling, where a combinational divider would not meet timing.

---
 rtl/fir_div_pkg.sv | 18 +
 rtl/signed_abs.sv | 23 ++
 rtl/signed_divider_seq.sv | 175 +++++++++++++++++
 tb/tb_signed_divider_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_div_pkg.sv
// fir_div_pkg
// Shared definitions for the sequential signed divider:
//   state_t      - 2-bit FSM encoding (IDLE, CALC, FIX, DONE)
//   step_cnt_w() - width of the quotient-bit step counter for an n-bit dividend
package fir_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int step_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/signed_abs.sv
// signed_abs
// Combinational two's-complement conditional negation.
// When used as a magnitude unit, neg is tied to the operand MSB, so y = |a|
// as an unsigned W-bit value (the most-negative input maps to 2^(W-1)).
// When used to re-apply a sign, neg selects y = -a.
// Ports:
//   a    in  W  operand
//   neg  in  1  negate a when high
//   y    out W  a or -a
//   sign out 1  MSB of a
module signed_abs #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y,
    output logic         sign
);

    assign sign = a[W-1];
    assign y    = neg ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/signed_divider_seq.sv
// signed_divider_seq
// Sequential restoring signed divider, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clk      in  1  rising-edge clock
//   rst      in  1  synchronous active-high reset
//   start    in  1  launch request, accepted in IDLE or DONE
//   dividend in  N  signed dividend, sampled on accepted start
//   divisor  in  m  signed divisor, sampled on accepted start
//   busy     out 1  high in CALC and FIX
//   done     out 1  one-cycle pulse when results are valid
//   quo      out N  signed quotient
//   rem      out m  signed remainder
//   dbz      out 1  divide-by-zero flag
//   ovf      out 1  quotient overflow flag (-2^(N-1) / -1)
module signed_divider_seq
    import fir_div_pkg::*;
#(
    parameter int N = 32,
    parameter int m = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [m-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quo,
    output logic [m-1:0] rem,
    output logic         dbz,
    output logic         ovf
);

    localparam int CW = step_cnt_w(N);

    state_t        state;
    logic [CW-1:0] cnt;

    // Operand magnitudes and latched signs
    logic [N-1:0]  dvd_mag;
    logic [m-1:0]  dsr_mag;
    logic          dvd_sign;
    logic          dsr_sign;

    // Working registers: q_p starts as |dividend| and fills with quotient bits
    // from the right as the dividend bits are consumed from the left.
    logic [N-1:0]  q_p;
    logic [m:0]    rem_p;
    logic [m-1:0]  dsr_p;
    logic          rsign_p;
    logic          dsign_p;
    logic          dbz_p;
    logic          ovf_p;

    logic [m:0]    shifted;
    logic [m+1:0]  diff;
    logic          take;

    logic [N-1:0]  quo_fix;
    logic [m-1:0]  rem_fix;
    logic          quo_sign_unused;
    logic          rem_sign_unused;

    signed_abs #(.W(N)) u_abs_dvd (
        .a    (dividend),
        .neg  (dividend[N-1]),
        .y    (dvd_mag),
        .sign (dvd_sign)
    );

    signed_abs #(.W(m)) u_abs_dsr (
        .a    (divisor),
        .neg  (divisor[m-1]),
        .y    (dsr_mag),
        .sign (dsr_sign)
    );

    signed_abs #(.W(N)) u_neg_quo (
        .a    (q_p),
        .neg  (rsign_p),
        .y    (quo_fix),
        .sign (quo_sign_unused)
    );

    signed_abs #(.W(m)) u_neg_rem (
        .a    (rem_p[m-1:0]),
        .neg  (dsign_p),
        .y    (rem_fix),
        .sign (rem_sign_unused)
    );

    // Restoring step: the partial remainder is always below |divisor| <= 2^(m-1),
    // so the shifted value fits m+1 bits; one extra bit exposes the borrow.
    always_comb begin
        shifted = {rem_p[m-1:0], q_p[N-1]};
        diff    = {1'b0, shifted} - {2'b00, dsr_p};
        take    = ~diff[m+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_p     <= dvd_mag;
                        dsr_p   <= dsr_mag;
                        rsign_p <= dvd_sign ^ dsr_sign;
                        dsign_p <= dvd_sign;
                        dbz_p   <= (divisor == '0);
                        ovf_p   <= (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
                        cnt     <= '0;
                        busy    <= 1'b1;
                        if (divisor == '0) begin
                            // Park the raw dividend bits here; FIX returns them as rem.
                            // Divide-by-zero skips CALC but still passes through FIX,
                            // so done arrives two cycles after start.
                            rem_p <= {1'b0, dividend[m-1:0]};
                            state <= FIX;
                        end else begin
                            rem_p <= '0;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    rem_p <= take ? diff[m:0] : shifted;
                    q_p   <= {q_p[N-2:0], take};
                    if (cnt == CW'(N - 1)) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FIX: begin
                    // For -2^(N-1) / -1 the magnitude 2^(N-1) with a positive
                    // result sign already wraps to the required 0x80..0.
                    if (dbz_p) begin
                        quo <= '1;
                        rem <= rem_p[m-1:0];
                    end else begin
                        quo <= quo_fix;
                        rem <= rem_fix;
                    end
                    dbz   <= dbz_p;
                    ovf   <= ovf_p;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_seq.sv
// tb_signed_divider_seq
// Self-checking bench for signed_divider_seq (N=32, m=16): directed vector
// table, hand-written multi-cycle sequences, and randomized vectors checked
// against an arithmetic reference model.
module tb_signed_divider_seq;

    localparam int N = 32;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quo;
    logic [M-1:0] rem;
    logic         dbz;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    signed_divider_seq #(.N(N), .m(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem      (rem),
        .dbz      (dbz),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        logic        o;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer division truncating toward zero.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic z, output logic o);
        longint sa, sb, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z = 1'b0;
        o = 1'b0;
        if (sb == 0) begin
            z = 1'b1;
            q = 32'hFFFF_FFFF;
            r = a[15:0];
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            if (qq > 64'sd2147483647) o = 1'b1;
            q = qq[31:0];
            r = rr[15:0];
        end
    endfunction

    // Present operands with start for one edge, then scramble the operand inputs.
    task automatic launch(input logic [31:0] a, input logic [15:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
    endtask

    // Wait (bounded) for done; lat is the cycle index at which done is seen.
    task automatic wait_done(input int c0, output int lat, output int busy_bad);
        lat = c0;
        busy_bad = 0;
        while (!done && lat < 200) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] eq, input logic [15:0] er,
                                input logic ez, input logic eo, input int elat,
                                input int lat, input int busy_bad);
        chk({tag, ".lat"}, 64'(lat), 64'(elat));
        chk({tag, ".quo"}, 64'(quo), 64'(eq));
        chk({tag, ".rem"}, 64'(rem), 64'(er));
        chk({tag, ".dbz"}, 64'(dbz), 64'(ez));
        chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
        chk({tag, ".busy_gap"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        int lat, bb, dones;
        logic [31:0] a, eq;
        logic [15:0] b, er;
        logic ez, eo;

        tbl[0]  = '{32'd100,       16'd7,      32'd14,        16'd2,      1'b0, 1'b0, 34};
        tbl[1]  = '{32'hFFFFFF9C,  16'd7,      32'hFFFFFFF2,  16'hFFFE,   1'b0, 1'b0, 34};
        tbl[2]  = '{32'd100,       16'hFFF9,   32'hFFFFFFF2,  16'h0002,   1'b0, 1'b0, 34};
        tbl[3]  = '{32'hFFFFFF9C,  16'hFFF9,   32'd14,        16'hFFFE,   1'b0, 1'b0, 34};
        tbl[4]  = '{32'd0,         16'd5,      32'd0,         16'd0,      1'b0, 1'b0, 34};
        tbl[5]  = '{32'd1234,      16'd0,      32'hFFFFFFFF,  16'h04D2,   1'b1, 1'b0, 2};
        tbl[6]  = '{32'h80000000,  16'hFFFF,   32'h80000000,  16'h0000,   1'b0, 1'b1, 34};
        tbl[7]  = '{32'h80000000,  16'h8000,   32'd65536,     16'h0000,   1'b0, 1'b0, 34};
        tbl[8]  = '{32'h7FFFFFFF,  16'd1,      32'h7FFFFFFF,  16'h0000,   1'b0, 1'b0, 34};
        tbl[9]  = '{32'hFFFFFFFF,  16'd0,      32'hFFFFFFFF,  16'hFFFF,   1'b1, 1'b0, 2};
        tbl[10] = '{32'h7FFFFFFF,  16'h8000,   32'hFFFF0001,  16'h7FFF,   1'b0, 1'b0, 34};
        tbl[11] = '{32'h80000000,  16'h7FFF,   32'hFFFEFFFE,  16'hFFFE,   1'b0, 1'b0, 34};

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.quo",  64'(quo),  64'd0);
        chk("reset.rem",  64'(rem),  64'd0);
        chk("reset.dbz",  64'(dbz),  64'd0);
        chk("reset.ovf",  64'(ovf),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            launch(tbl[i].a, tbl[i].b);
            wait_done(1, lat, bb);
            check_result($sformatf("tbl%0d", i), tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].o,
                         tbl[i].lat, lat, bb);
            chk($sformatf("tbl%0d.busy_at_done", i), 64'(busy), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d.done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("tbl%0d.quo_hold", i), 64'(quo), 64'(tbl[i].q));
        end

        // Reset in the middle of a division: outputs cleared, no done pulse
        launch(32'd50, 16'd5);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.quo",  64'(quo),  64'd0);
        chk("midrst.rem",  64'(rem),  64'd0);
        chk("midrst.dbz",  64'(dbz),  64'd0);
        chk("midrst.ovf",  64'(ovf),  64'd0);
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("midrst.no_done", 64'(dones), 64'd0);
        launch(32'd50, 16'd5);
        wait_done(1, lat, bb);
        check_result("after_rst", 32'd10, 16'd0, 1'b0, 1'b0, 34, lat, bb);

        // start while busy is ignored
        @(posedge clk); #1;
        launch(32'd100, 16'd7);
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1;
        dividend = 32'd9;
        divisor = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(7, lat, bb);
        check_result("poke", 32'd14, 16'd2, 1'b0, 1'b0, 34, lat, bb);

        // Back-to-back: start held in the DONE cycle
        start = 1'b1;
        dividend = 32'd9;
        divisor = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.busy", 64'(busy), 64'd1);
        chk("b2b.quo_kept", 64'(quo), 64'd14);
        wait_done(1, lat, bb);
        check_result("b2b", 32'd4, 16'd1, 1'b0, 1'b0, 34, lat, bb);
        @(posedge clk); #1;

        // Randomized vectors against the reference model
        for (int k = 0; k < 200; k++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 16'd0;
                1: b = 16'hFFFF;
                2: b = 16'($urandom_range(1, 20));
                3: b = 16'h8000;
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            model(a, b, eq, er, ez, eo);
            launch(a, b);
            wait_done(1, lat, bb);
            check_result($sformatf("rnd%0d", k), eq, er, ez, eo, ez ? 2 : 34, lat, bb);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
